// File: rtl/nibble_word_assembler_if.sv
// Digit-entry bus between a keypad/UART digit source and the nibble word assembler.
// master = digit source / controller side, slave = assembler side.
interface nibble_word_assembler_if #(
  parameter int N_DIGITS = 8
);
  localparam int W = 4 * N_DIGITS;

  logic [3:0]   digit_in;
  logic         digit_valid;
  logic         digit_ready;
  logic         backspace;
  logic         clear;
  logic         commit;
  logic [W-1:0] live_word;
  logic [3:0]   digit_count;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         full;
  logic         overflow;
  logic         digit_err;

  modport master (
    output digit_in, digit_valid, backspace, clear, commit,
    input  digit_ready, live_word, digit_count, word_out, word_valid,
           full, overflow, digit_err
  );

  modport slave (
    input  digit_in, digit_valid, backspace, clear, commit,
    output digit_ready, live_word, digit_count, word_out, word_valid,
           full, overflow, digit_err
  );
endinterface

// File: rtl/nibble_word_assembler.sv
// Calculator-style digit entry: newest digit enters at [3:0], older digits shift up a nibble.
// live_word/digit_count update 1 cycle after accept; digit_ready drops while FULL and for the DONE cycle.
module nibble_word_assembler #(
  parameter int N_DIGITS = 8,
  parameter bit BCD_MODE = 1'b0
) (
  input logic                    clk,
  input logic                    reset,
  nibble_word_assembler_if.slave bus
);
  localparam int W = 4 * N_DIGITS;
  localparam logic [3:0] N_CNT = 4'(N_DIGITS);

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] PARTIAL = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]   state;
  logic [W-1:0] live_word;
  logic [W-1:0] word_out;
  logic [3:0]   count;
  logic         overflow;
  logic         digit_err;

  logic ready;
  logic has_digits;
  logic accept;
  logic illegal;

  assign ready      = (state == EMPTY) || (state == PARTIAL);
  assign has_digits = (state == PARTIAL) || (state == FULL);
  assign accept     = bus.digit_valid && ready;
  assign illegal    = BCD_MODE && (bus.digit_in > 4'd9);

  // Priority chain: clear > DONE exit > commit > backspace > digit accept.
  // An illegal BCD digit still completes its handshake but leaves state untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      live_word <= '0;
      word_out  <= '0;
      count     <= 4'd0;
      overflow  <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      digit_err <= 1'b0;
      if (bus.clear) begin
        live_word <= '0;
        count     <= 4'd0;
        overflow  <= 1'b0;
        state     <= EMPTY;
      end else if (state == DONE) begin
        state <= EMPTY;
      end else if (bus.commit && has_digits) begin
        word_out  <= live_word;
        live_word <= '0;
        count     <= 4'd0;
        overflow  <= 1'b0;
        state     <= DONE;
      end else if (bus.backspace && has_digits) begin
        live_word <= live_word >> 4;
        count     <= count - 4'd1;
        state     <= (count == 4'd1) ? EMPTY : PARTIAL;
      end else begin
        if (bus.digit_valid && (state == FULL)) begin
          overflow <= 1'b1;
        end
        if (accept) begin
          if (illegal) begin
            digit_err <= 1'b1;
          end else begin
            live_word <= (live_word << 4) | W'(bus.digit_in);
            count     <= count + 4'd1;
            state     <= ((count + 4'd1) == N_CNT) ? FULL : PARTIAL;
          end
        end
      end
    end
  end

  assign bus.digit_ready = ready;
  assign bus.live_word   = live_word;
  assign bus.digit_count = count;
  assign bus.word_out    = word_out;
  assign bus.word_valid  = (state == DONE);
  assign bus.full        = (state == FULL);
  assign bus.overflow    = overflow;
  assign bus.digit_err   = digit_err;
endmodule

// File: tb/tb_nibble_word_assembler.sv
// Bench for nibble_word_assembler: hex (dut) and BCD (dut_bcd) instances share one stimulus
// stream and are checked against a digit-list reference model.
module tb_nibble_word_assembler;
  localparam int N = 8;
  localparam int W = 4 * N;
  localparam int VW = 2 * W + 9;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d_in;
  logic       d_vld, bksp, clr, cmt;

  int checks = 0;
  int errors = 0;

  nibble_word_assembler_if #(.N_DIGITS(N)) a_if ();
  nibble_word_assembler_if #(.N_DIGITS(N)) b_if ();

  assign a_if.digit_in = d_in;  assign b_if.digit_in = d_in;
  assign a_if.digit_valid = d_vld;  assign b_if.digit_valid = d_vld;
  assign a_if.backspace = bksp;  assign b_if.backspace = bksp;
  assign a_if.clear = clr;  assign b_if.clear = clr;
  assign a_if.commit = cmt;  assign b_if.commit = cmt;

  nibble_word_assembler #(.N_DIGITS(N), .BCD_MODE(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(a_if.slave)
  );
  nibble_word_assembler #(.N_DIGITS(N), .BCD_MODE(1'b1)) dut_bcd (
    .clk(clk), .reset(reset), .bus(b_if.slave)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of held digits (index 0 = oldest) per instance.
  int           mdig [2][N];
  int           mcnt [2];
  bit           mdone[2];
  bit           movf [2];
  bit           merr [2];
  logic [W-1:0] mword[2];

  function automatic logic [W-1:0] m_live(int k);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < mcnt[k]; i++) v = v * 16 + W'(mdig[k][i]);
    return v;
  endfunction

  function automatic logic [VW-1:0] m_expect(int k);
    logic [VW-1:0] e;
    e = {m_live(k), 4'(mcnt[k]), mword[k], mdone[k], (mcnt[k] == N), movf[k], merr[k],
         (!mdone[k] && mcnt[k] < N)};
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mdone[k] = 0; movf[k] = 0; merr[k] = 0; mword[k] = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      merr[k] = 0;
      if (clr) begin
        mcnt[k] = 0; movf[k] = 0; mdone[k] = 0;
      end else if (mdone[k]) begin
        mdone[k] = 0;
      end else if (cmt && mcnt[k] > 0) begin
        mword[k] = m_live(k); mcnt[k] = 0; movf[k] = 0; mdone[k] = 1;
      end else if (bksp && mcnt[k] > 0) begin
        mcnt[k]--;
      end else if (d_vld) begin
        if (mcnt[k] == N) movf[k] = 1;
        else if (k == 1 && d_in > 9) merr[k] = 1;
        else begin
          mdig[k][mcnt[k]] = int'(d_in);
          mcnt[k]++;
        end
      end
    end
  endtask

  task automatic idle();
    d_vld = 0; bksp = 0; clr = 0; cmt = 0; d_in = 4'h0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_digit(input logic [3:0] d);
    d_in = d; d_vld = 1; tick(); idle();
  endtask

  task automatic pulse_clear();
    clr = 1; tick(); idle();
  endtask

  task automatic test_reset();
    checks++;
    if (a_if.live_word !== '0 || a_if.digit_count !== 4'd0 || a_if.word_out !== '0) begin
      errors++;
      $display("FAIL reset_regs: live=%h count=%0d word=%h, expected all 0",
               a_if.live_word, a_if.digit_count, a_if.word_out);
    end
    checks++;
    if ({a_if.word_valid, a_if.overflow, a_if.digit_err, a_if.full, a_if.digit_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags: vld/ovf/err/full/rdy=%b expected 00001",
               {a_if.word_valid, a_if.overflow, a_if.digit_err, a_if.full, a_if.digit_ready});
    end
  endtask

  task automatic test_type_four();
    for (int i = 1; i <= 4; i++) put_digit(4'(i));
    checks++;
    if (a_if.live_word !== 32'h0000_1234 || a_if.digit_count !== 4'd4 || a_if.digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL type_four: live=%h count=%0d rdy=%b expected 00001234 4 1",
               a_if.live_word, a_if.digit_count, a_if.digit_ready);
    end
  endtask

  task automatic test_fill_overflow_commit();
    for (int i = 5; i <= 8; i++) put_digit(4'(i));
    checks++;
    if (a_if.live_word !== 32'h1234_5678 || a_if.full !== 1'b1 || a_if.digit_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill: live=%h full=%b rdy=%b expected 12345678 1 0",
               a_if.live_word, a_if.full, a_if.digit_ready);
    end
    put_digit(4'h9);
    checks++;
    if (a_if.overflow !== 1'b1 || a_if.live_word !== 32'h1234_5678) begin
      errors++;
      $display("FAIL overflow: ovf=%b live=%h expected 1 12345678", a_if.overflow, a_if.live_word);
    end
    cmt = 1; tick(); idle();
    checks++;
    if (a_if.word_out !== 32'h1234_5678 || a_if.word_valid !== 1'b1 ||
        a_if.digit_count !== 4'd0 || a_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL commit: word=%h vld=%b count=%0d ovf=%b expected 12345678 1 0 0",
               a_if.word_out, a_if.word_valid, a_if.digit_count, a_if.overflow);
    end
    // Digit offered during the DONE cycle must be ignored.
    d_in = 4'h2; d_vld = 1; tick();
    checks++;
    if (a_if.word_valid !== 1'b0 || a_if.digit_count !== 4'd0 || a_if.digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_exit: vld=%b count=%0d rdy=%b expected 0 0 1",
               a_if.word_valid, a_if.digit_count, a_if.digit_ready);
    end
    tick(); idle();
    checks++;
    if (a_if.live_word !== 32'h2) begin
      errors++;
      $display("FAIL back_to_back: live=%h expected 00000002", a_if.live_word);
    end
  endtask

  task automatic test_backspace();
    pulse_clear();
    for (int i = 1; i <= 3; i++) put_digit(4'(i));
    bksp = 1; tick(); idle();
    checks++;
    if (a_if.live_word !== 32'h12 || a_if.digit_count !== 4'd2) begin
      errors++;
      $display("FAIL backspace: live=%h count=%0d expected 12 2", a_if.live_word, a_if.digit_count);
    end
    bksp = 1; d_in = 4'h5; d_vld = 1; tick();
    checks++;
    if (a_if.live_word !== 32'h1 || a_if.digit_count !== 4'd1) begin
      errors++;
      $display("FAIL bksp_digit: live=%h count=%0d expected 1 1", a_if.live_word, a_if.digit_count);
    end
    bksp = 0; tick(); idle();
    checks++;
    if (a_if.live_word !== 32'h15 || a_if.digit_count !== 4'd2) begin
      errors++;
      $display("FAIL held_digit: live=%h count=%0d expected 15 2", a_if.live_word, a_if.digit_count);
    end
  endtask

  task automatic test_clear_commit();
    logic [W-1:0] prev;
    pulse_clear();
    cmt = 1; tick(); idle();
    prev = a_if.word_out;
    put_digit(4'hA); put_digit(4'hB);
    clr = 1; cmt = 1; tick(); idle();
    checks++;
    if (a_if.live_word !== '0 || a_if.word_out !== prev || a_if.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_commit: live=%h word=%h vld=%b expected 0 %h 0",
               a_if.live_word, a_if.word_out, a_if.word_valid, prev);
    end
  endtask

  task automatic test_commit_empty();
    pulse_clear();
    cmt = 1; tick(); idle();
    checks++;
    if (a_if.word_valid !== 1'b0 || a_if.word_out !== 32'h1234_5678) begin
      errors++;
      $display("FAIL commit_empty: vld=%b word=%h expected 0 12345678", a_if.word_valid, a_if.word_out);
    end
  endtask

  task automatic test_bcd();
    pulse_clear();
    put_digit(4'hC);
    checks++;
    if (b_if.digit_err !== 1'b1 || b_if.live_word !== '0 || b_if.digit_count !== 4'd0) begin
      errors++;
      $display("FAIL bcd_reject: err=%b live=%h count=%0d expected 1 0 0",
               b_if.digit_err, b_if.live_word, b_if.digit_count);
    end
    put_digit(4'h7);
    checks++;
    if (b_if.digit_err !== 1'b0 || b_if.live_word !== 32'h7) begin
      errors++;
      $display("FAIL bcd_accept: err=%b live=%h expected 0 7", b_if.digit_err, b_if.live_word);
    end
  endtask

  task automatic test_async_reset();
    put_digit(4'h4); put_digit(4'h2);
    @(negedge clk);
    #2 reset = 1;
    #1;
    model_reset();
    checks++;
    if (a_if.live_word !== '0 || a_if.word_out !== '0 || a_if.digit_count !== 4'd0 ||
        a_if.word_valid !== 1'b0 || a_if.digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: live=%h word=%h count=%0d vld=%b rdy=%b expected 0 0 0 0 1",
               a_if.live_word, a_if.word_out, a_if.digit_count, a_if.word_valid, a_if.digit_ready);
    end
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp;
    for (int n = 0; n < 3000; n++) begin
      d_in  = 4'($urandom_range(0, 15));
      d_vld = ($urandom_range(0, 99) < 60);
      bksp  = ($urandom_range(0, 99) < 10);
      clr   = ($urandom_range(0, 99) < 3);
      cmt   = ($urandom_range(0, 99) < 6);
      tick();
      got = {a_if.live_word, a_if.digit_count, a_if.word_out, a_if.word_valid, a_if.full,
             a_if.overflow, a_if.digit_err, a_if.digit_ready};
      exp = m_expect(0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_hex cycle %0d: got %h expected %h", n, got, exp);
      end
      got = {b_if.live_word, b_if.digit_count, b_if.word_out, b_if.word_valid, b_if.full,
             b_if.overflow, b_if.digit_err, b_if.digit_ready};
      exp = m_expect(1);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_bcd cycle %0d: got %h expected %h", n, got, exp);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 0;
    test_type_four();
    test_fill_overflow_commit();
    test_backspace();
    test_clear_commit();
    test_commit_empty();
    test_bcd();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
